// File: rtl/playfield_pkg.sv
// rtl/playfield_pkg.sv - colour constants and elaboration helpers for playfield_renderer
package playfield_pkg;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BULLET = 3'b111;
  localparam logic [2:0] COL_SHIP   = 3'b010;
  localparam logic [2:0] COL_FLASH  = 3'b110;
  localparam logic [2:0] COL_INV    = 3'b100;
  localparam logic [2:0] COL_GRID   = 3'b001;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cell_shape.sv
// rtl/cell_shape.sv - per-cell sprite masks from the pixel offset inside a cell
module cell_shape #(
  parameter int CELL_LOG2 = 5
) (
  input  logic [CELL_LOG2-1:0] ox,
  input  logic [CELL_LOG2-1:0] oy,
  input  logic [CELL_LOG2-1:0] inset,
  output logic                 invShape,
  output logic                 shipShape,
  output logic                 bulletShape
);

  localparam int S    = 1 << CELL_LOG2;
  localparam int HALF = S / 2;

  int oxI;
  int oyI;
  int insetI;

  assign oxI    = int'(ox);
  assign oyI    = int'(oy);
  assign insetI = int'(inset);

  assign invShape    = (oxI >= insetI) && (oxI < S - insetI) &&
                       (oyI >= insetI) && (oyI < S - insetI);
  assign shipShape   = (oyI >= HALF) && (oxI >= 2) && (oxI < S - 2);
  // Bullet is a 4-pixel-wide vertical bar centred in the cell.
  assign bulletShape = (oxI >= HALF - 2) && (oxI <= HALF + 1);

endmodule

// File: rtl/playfield_renderer.sv
// rtl/playfield_renderer.sv - 2-stage pixel colour pipeline for the invader playfield
// Optional macro GRID_OVERLAY_EN draws a blue debug grid on background pixels.
module playfield_renderer
  import playfield_pkg::*;
#(
  parameter int FIELD_COLS   = 20,
  parameter int FIELD_ROWS   = 15,
  parameter int INV_ROWS     = 1,
  parameter int CELL_LOG2    = 5,
  parameter int NB           = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ANIM_DIV     = 16,
  parameter int FLASH_FRAMES = 8,
  localparam int RW = clog2(FIELD_ROWS),
  localparam int CW = clog2(FIELD_COLS)
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           pix_valid,
  input  logic [9:0]                     VGAx,
  input  logic [9:0]                     VGAy,
  input  logic [FIELD_COLS*INV_ROWS-1:0] invArray,
  input  logic [RW-1:0]                  invLine,
  input  logic [CW-1:0]                  shipX,
  input  logic [NB*CW-1:0]               bulletX,
  input  logic [NB*RW-1:0]               bulletY,
  input  logic [NB-1:0]                  bulletFlying,
  input  logic                           hit_valid,
  input  logic [CW-1:0]                  hit_col,
  input  logic [RW-1:0]                  hit_row,
  output logic [2:0]                     rgb,
  output logic                           rgb_valid
);

  localparam int PW  = 10 - CELL_LOG2;
  localparam int FW  = (clog2(ANIM_DIV) < 1) ? 1 : clog2(ANIM_DIV);
  localparam int FLW = clog2(FLASH_FRAMES + 1);

  logic [PW-1:0]        s1Col;
  logic [PW-1:0]        s1Row;
  logic [CELL_LOG2-1:0] s1Ox;
  logic [CELL_LOG2-1:0] s1Oy;
  logic                 s1Vis;
  logic                 s1Valid;

  logic [FW-1:0]        frameCnt;
  logic                 animPhase;
  logic [FLW-1:0]       flashCnt;
  logic [CW-1:0]        hitCol;
  logic [RW-1:0]        hitRow;

  logic                 frameTick;
  logic [CELL_LOG2-1:0] inset;
  logic                 invShape;
  logic                 shipShape;
  logic                 bulletShape;
  logic                 bulletHit;
  logic                 invHit;
  logic [2:0]           nextRgb;
  int                   colI;
  int                   rowI;

  assign frameTick = pix_valid && (VGAx == 10'd0) && (VGAy == 10'(V_ACTIVE));
  assign inset     = animPhase ? CELL_LOG2'(4) : CELL_LOG2'(2);
  assign colI      = int'(s1Col);
  assign rowI      = int'(s1Row);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1Col   <= '0;
      s1Row   <= '0;
      s1Ox    <= '0;
      s1Oy    <= '0;
      s1Vis   <= 1'b0;
      s1Valid <= 1'b0;
    end else begin
      s1Col   <= VGAx[9:CELL_LOG2];
      s1Row   <= VGAy[9:CELL_LOG2];
      s1Ox    <= VGAx[CELL_LOG2-1:0];
      s1Oy    <= VGAy[CELL_LOG2-1:0];
      s1Vis   <= (VGAx < 10'(H_ACTIVE)) && (VGAy < 10'(V_ACTIVE));
      s1Valid <= pix_valid;
    end
  end

  // A hit report on a tick cycle reloads the full flash duration.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      frameCnt  <= '0;
      animPhase <= 1'b0;
      flashCnt  <= '0;
      hitCol    <= '0;
      hitRow    <= '0;
    end else begin
      if (frameTick) begin
        if (frameCnt == FW'(ANIM_DIV - 1)) begin
          frameCnt  <= '0;
          animPhase <= ~animPhase;
        end else begin
          frameCnt <= frameCnt + 1'b1;
        end
      end
      if (hit_valid) begin
        hitCol   <= hit_col;
        hitRow   <= hit_row;
        flashCnt <= FLW'(FLASH_FRAMES);
      end else if (frameTick && (flashCnt != '0)) begin
        flashCnt <= flashCnt - 1'b1;
      end
    end
  end

  cell_shape #(
    .CELL_LOG2(CELL_LOG2)
  ) u_shape (
    .ox         (s1Ox),
    .oy         (s1Oy),
    .inset      (inset),
    .invShape   (invShape),
    .shipShape  (shipShape),
    .bulletShape(bulletShape)
  );

  always_comb begin
    logic [CW-1:0]                  bx;
    logic [RW-1:0]                  by;
    logic [FIELD_COLS*INV_ROWS-1:0] invBits;
    bulletHit = 1'b0;
    invHit    = 1'b0;
    bx        = '0;
    by        = '0;
    invBits   = '0;
    for (int b = 0; b < NB; b++) begin
      bx = CW'(bulletX >> (b * CW));
      by = RW'(bulletY >> (b * RW));
      if (bulletFlying[b] && (int'(bx) == colI) && (int'(by) == rowI)) bulletHit = 1'b1;
    end
    // Rows past the field bottom are clipped rather than wrapped.
    for (int r = 0; r < INV_ROWS; r++) begin
      if ((rowI == int'(invLine) + r) && (rowI < FIELD_ROWS) && (colI < FIELD_COLS)) begin
        invBits = invArray >> (r * FIELD_COLS + colI);
        invHit  = invHit | invBits[0];
      end
    end
  end

  always_comb begin
    nextRgb = COL_BLACK;
    if (!s1Vis)
      nextRgb = COL_BLACK;
    else if (bulletHit && bulletShape)
      nextRgb = COL_BULLET;
    else if ((colI == int'(shipX)) && (rowI == FIELD_ROWS - 1) && shipShape)
      nextRgb = COL_SHIP;
    else if ((flashCnt != '0) && (colI == int'(hitCol)) && (rowI == int'(hitRow)) && invShape)
      nextRgb = COL_FLASH;
    else if (invHit && invShape)
      nextRgb = COL_INV;
`ifdef GRID_OVERLAY_EN
    else if ((s1Ox == '0) || (s1Oy == '0))
      nextRgb = COL_GRID;
`endif
    else
      nextRgb = COL_BLACK;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rgb       <= COL_BLACK;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= nextRgb;
      rgb_valid <= s1Valid;
    end
  end

endmodule

// File: tb/tb_playfield_renderer.sv
// tb/tb_playfield_renderer.sv - directed self-checking bench for playfield_renderer
module tb_playfield_renderer;

  logic        clk = 1'b0;
  logic        clr;
  logic        pix_valid;
  logic [9:0]  VGAx;
  logic [9:0]  VGAy;
  logic [19:0] invArray;
  logic [3:0]  invLine;
  logic [4:0]  shipX;
  logic [9:0]  bulletX;
  logic [7:0]  bulletY;
  logic [1:0]  bulletFlying;
  logic        hit_valid;
  logic [4:0]  hit_col;
  logic [3:0]  hit_row;
  logic [2:0]  rgb;
  logic        rgb_valid;

  int nChecks = 0;
  int nErrors = 0;

  playfield_renderer dut (
    .clk         (clk),
    .clr         (clr),
    .pix_valid   (pix_valid),
    .VGAx        (VGAx),
    .VGAy        (VGAy),
    .invArray    (invArray),
    .invLine     (invLine),
    .shipX       (shipX),
    .bulletX     (bulletX),
    .bulletY     (bulletY),
    .bulletFlying(bulletFlying),
    .hit_valid   (hit_valid),
    .hit_col     (hit_col),
    .hit_row     (hit_row),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clr       = 1'b0;
    pix_valid = 1'b0;
    hit_valid = 1'b0;
    step();
    step();
    clr = 1'b1;
  endtask

  task automatic probe(input int x, input int y, input logic [2:0] exp, input string tag);
    VGAx      = 10'(x);
    VGAy      = 10'(y);
    pix_valid = 1'b1;
    step();
    step();
    check(tag, {29'd0, rgb}, {29'd0, exp});
  endtask

  task automatic frameTick();
    VGAx      = 10'd0;
    VGAy      = 10'd480;
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic hitPulse(input int col, input int row);
    hit_col   = 5'(col);
    hit_row   = 4'(row);
    hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
  endtask

  initial begin
    clr          = 1'b0;
    pix_valid    = 1'b0;
    VGAx         = 10'd0;
    VGAy         = 10'd0;
    invArray     = 20'h1;
    invLine      = 4'd11;
    shipX        = 5'd0;
    bulletX      = '0;
    bulletY      = '0;
    bulletFlying = 2'b00;
    hit_valid    = 1'b0;
    hit_col      = '0;
    hit_row      = '0;

    // Reset held while pixels stream in
    for (int i = 0; i < 4; i++) begin
      VGAx      = 10'(16 + i);
      VGAy      = 10'd368;
      pix_valid = 1'(i % 2);
      step();
    end
    pix_valid = 1'b1;
    step();
    check("reset_rgb", {29'd0, rgb}, 32'd0);
    check("reset_valid", {31'd0, rgb_valid}, 32'd0);

    // Latency: idle background first, then one invader pixel
    pix_valid = 1'b0;
    VGAx      = 10'd700;
    VGAy      = 10'd10;
    clr       = 1'b1;
    step();
    step();
    VGAx      = 10'd16;
    VGAy      = 10'd368;
    pix_valid = 1'b1;
    step();
    check("lat1_rgb", {29'd0, rgb}, 32'd0);
    check("lat1_valid", {31'd0, rgb_valid}, 32'd0);
    step();
    check("lat2_rgb", {29'd0, rgb}, 32'h4);
    check("lat2_valid", {31'd0, rgb_valid}, 32'd1);
    pix_valid = 1'b0;
    step();
    check("lat3_valid", {31'd0, rgb_valid}, 32'd1);
    step();
    check("lat4_valid", {31'd0, rgb_valid}, 32'd0);

    // Invader inset edges
    probe(1, 368, 3'b000, "inv_ox1");
    probe(2, 368, 3'b100, "inv_ox2");
    probe(29, 368, 3'b100, "inv_ox29");
    probe(30, 368, 3'b000, "inv_ox30");
    probe(48, 368, 3'b000, "inv_col1_absent");
    probe(16, 336, 3'b000, "inv_row10");
    probe(0, 0, 3'b000, "background");

    // Bullets
    invArray     = 20'h0;
    bulletX      = {5'd3, 5'd0};
    bulletY      = {4'd4, 4'd0};
    bulletFlying = 2'b10;
    probe(112, 136, 3'b111, "bullet_ch1");
    probe(109, 136, 3'b000, "bullet_ox13");
    probe(110, 136, 3'b111, "bullet_ox14");
    probe(113, 136, 3'b111, "bullet_ox17");
    probe(114, 136, 3'b000, "bullet_ox18");
    probe(700, 10, 3'b000, "invisible");
    bulletFlying = 2'b00;
    probe(112, 136, 3'b000, "bullet_off");
    bulletX      = {5'd0, 5'd3};
    bulletY      = {4'd0, 4'd4};
    bulletFlying = 2'b01;
    probe(112, 136, 3'b111, "bullet_ch0");
    bulletFlying = 2'b10;
    probe(112, 136, 3'b000, "bullet_ch1_elsewhere");

    // Ship and priority
    shipX        = 5'd3;
    bulletX      = {5'd3, 5'd0};
    bulletY      = {4'd14, 4'd0};
    bulletFlying = 2'b10;
    probe(112, 472, 3'b111, "prio_bullet_ship");
    bulletFlying = 2'b00;
    probe(112, 472, 3'b010, "ship");
    probe(112, 456, 3'b000, "ship_upper_half");
    probe(144, 472, 3'b000, "ship_other_col");

    // Flash lasts 8 ticks
    doReset();
    invArray = 20'h0;
    invLine  = 4'd11;
    hitPulse(0, 11);
    probe(16, 368, 3'b110, "flash_t0");
    for (int t = 1; t <= 8; t++) begin
      frameTick();
      probe(16, 368, (t < 8) ? 3'b110 : 3'b000, $sformatf("flash_t%0d", t));
    end

    // Re-hit after 3 ticks moves the flash and restarts it
    doReset();
    hitPulse(0, 11);
    for (int t = 0; t < 3; t++) frameTick();
    hitPulse(1, 11);
    probe(16, 368, 3'b000, "rehit_old_cell");
    probe(48, 368, 3'b110, "rehit_new_t0");
    for (int t = 1; t <= 8; t++) begin
      frameTick();
      probe(48, 368, (t < 8) ? 3'b110 : 3'b000, $sformatf("rehit_t%0d", t));
    end

    // Hit coinciding with a tick: the load wins
    doReset();
    hit_col   = 5'd2;
    hit_row   = 4'd11;
    hit_valid = 1'b1;
    VGAx      = 10'd0;
    VGAy      = 10'd480;
    pix_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    pix_valid = 1'b0;
    for (int t = 0; t < 7; t++) frameTick();
    probe(80, 368, 3'b110, "coincide_t7");
    frameTick();
    probe(80, 368, 3'b000, "coincide_t8");

    // Animation phase toggles every 16 ticks
    doReset();
    invArray = 20'h1;
    invLine  = 4'd11;
    for (int t = 0; t <= 32; t++) begin
      if (t > 0) frameTick();
      probe(3, 371, (((t / 16) % 2) == 0) ? 3'b100 : 3'b000, $sformatf("anim_t%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/playfield_renderer.md
Name: playfield_renderer

Overview:
- Pipelined, parametrised successor to the combinational formatVGA pixel formatter.
- Maps each incoming VGA pixel coordinate to a 3-bit colour from a cell grid. The grid contains an invader block of INV_ROWS rows, one ship, NB independent bullets and a timed hit-flash cell.
- Adds registered 2-cycle latency, frame-based invader animation and hit flash.
- Sits between the game-state logic and the VGA sync/DAC stage.

Parameters:
- FIELD_COLS, 20: grid columns.
- FIELD_ROWS, 15: grid rows. Ship occupies row FIELD_ROWS-1.
- INV_ROWS, 1: invader rows drawn, starting at invLine.
- CELL_LOG2, 5: cell size is 2^CELL_LOG2 pixels square.
- NB, 2: bullet channels.
- H_ACTIVE, 640: visible width.
- V_ACTIVE, 480: visible height.
- ANIM_DIV, 16: frames per animation phase.
- FLASH_FRAMES, 8: frames a hit cell flashes.

Ports:
- clk  in  1  pixel clock.
- clr  in  1  asynchronous, active-low reset.
- pix_valid  in  1  VGAx/VGAy qualify this cycle.
- VGAx  in  10  pixel column.
- VGAy  in  10  pixel line.
- invArray  in  FIELD_COLS*INV_ROWS  invader present; bit r*FIELD_COLS+c.
- invLine  in  RW  top invader row. RW=clog2(FIELD_ROWS).
- shipX  in  CW  ship column. CW=clog2(FIELD_COLS).
- bulletX  in  NB*CW  packed columns, channel 0 at LSBs.
- bulletY  in  NB*RW  packed rows.
- bulletFlying  in  NB  per-channel enable.
- hit_valid  in  1  single-cycle hit report.
- hit_col  in  CW  hit column.
- hit_row  in  RW  hit row.
- rgb  out  3  pixel colour.
- rgb_valid  out  1  rgb qualifies; equals pix_valid delayed 2 cycles.

Behaviour:
- Reset (clr=0, async), all cleared: rgb=0, rgb_valid=0, pipeline registers, frame counter, anim_phase=0, flash_cnt=0.
- Stage 1 registers:
  - cell col = VGAx>>CELL_LOG2, cell row = VGAy>>CELL_LOG2;
  - inner offsets ox, oy = low CELL_LOG2 bits;
  - visible flag = VGAx<H_ACTIVE && VGAy<V_ACTIVE.
- Stage 2 registers rgb from the decisions below. Latency is exactly 2 cycles. Stages advance every cycle; pix_valid only travels as a tag.
- Frame tick: pix_valid && VGAx==0 && VGAy==V_ACTIVE. On each tick:
  - frame counter increments; at ANIM_DIV-1 it wraps to 0 and anim_phase toggles;
  - flash_cnt decrements if nonzero.
- Hit flash: hit_valid loads the cell coordinates and sets flash_cnt=FLASH_FRAMES. A new hit while flashing restarts with the new coordinates. hit_valid on the same cycle as a frame tick: the load wins.
- Shapes, with S=2^CELL_LOG2:
  - invader: inset I=2 (phase 0) or 4 (phase 1); drawn when I<=ox<S-I and I<=oy<S-I.
  - ship: oy>=S/2 and 2<=ox<S-2.
  - bullet: S/2-2<=ox<=S/2+1, any oy.
- Invader hit: row in [invLine, invLine+INV_ROWS-1] and its bit is set. Rows >=FIELD_ROWS are not drawn (no wrap). Columns >=FIELD_COLS never match.
- Colour priority, highest first:
  - not visible -> 000
  - any flying bullet shape -> 111
  - ship shape in (shipX, FIELD_ROWS-1) -> 010
  - flash_cnt!=0 and cell==hit cell, invader shape -> 110 (regardless of invArray)
  - invader -> 100
  - background -> 000
- Inputs other than VGAx/VGAy are sampled in stage 2. No synchronisation is required; the game logic updates them during blanking.

Optional Feature:
- GRID_OVERLAY_EN defined: background pixels with ox==0 or oy==0 inside the visible area render 001 (blue debug grid).
- GRID_OVERLAY_EN undefined: background is always 000. No extra logic.

Decomposition:
- Package playfield_pkg holds the colour constants (COL_BLACK, COL_BULLET, COL_SHIP, COL_FLASH, COL_INV, COL_GRID) and a clog2 function.
- One sub-module, cell_shape: combinational shape tests taking ox, oy, inset and CELL_LOG2. It is instantiated once in stage 2.

Test Plan (all default parameters):
- Reset: hold clr=0 while toggling pixels -> rgb=000, rgb_valid=0. Release clr -> rgb_valid follows pix_valid after 2 clk.
- Invader: invArray=20'h1, invLine=11, pixel (16,368) -> rgb=100 exactly 2 clk later. Pixel (1,368) -> 000 (outside inset).
- Bullets: channel 1 X=3, Y=4, flying=2'b10, pixel (112,136) -> 111. Flying=2'b00 -> 000. Pixel (700,10) -> 000.
- Priority: shipX=3, bullet1 at (3,14), pixel (112,472) -> 111. Same pixel with the bullet off -> 010.
- Flash: hit_valid col 0, row 11, invArray=0, pixel (16,368) -> 110 for 8 frame ticks, then 000. A second hit at (1,11) after 3 ticks -> flash moves and lasts 8 more ticks.
- Animation: invArray=20'h1, invLine=11, pixel (3,371) -> 100 for ticks 0-15, 000 after tick 16, 100 again after tick 32.
